// File: rtl/sid_pkg.sv
// Shared types and constants for the SID waveform generator and its noise register.
// The waveform-select struct is laid out MSB-first to match the control register bit order.
package sid_pkg;

  localparam int ACC_W  = 24;
  localparam int WAVE_W = 12;
  localparam int LFSR_W = 23;

  localparam logic [LFSR_W-1:0] LFSR_SEED = 23'h7FFFFF;
  localparam int LFSR_TAP_HI = 22;
  localparam int LFSR_TAP_LO = 17;

  // LFSR bits that feed noise output bits 11 down to 4.
  localparam int NOISE_IDX [8] = '{22, 20, 16, 13, 11, 7, 4, 2};

  typedef struct packed {
    logic noise;
    logic pulse;
    logic saw;
    logic triangle;
    logic ring_mod;
    logic test;
  } wave_ctrl_t;

  function automatic logic [WAVE_W-1:0] noise_bits(input logic [LFSR_W-1:0] l);
    logic [WAVE_W-1:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n[WAVE_W-1-i] = l[NOISE_IDX[i]];
    end
    return n;
  endfunction

endpackage

// File: rtl/sid_noise_lfsr.sv
// 23-bit noise shift register, stepped on each acc[19] rising edge seen at a clk_en tick.
// test forces the seed every tick and wins over a coincident step; everything holds without clk_en.
module sid_noise_lfsr
  import sid_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clk_en,
  input  logic              acc19,
  input  logic              test,
  output logic [LFSR_W-1:0] lfsr
);

  logic              acc19_q, acc19_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    acc19_d = acc19_q;
    lfsr_d  = lfsr_q;
    if (clk_en) begin
      acc19_d = acc19;
      if (test) begin
        lfsr_d = LFSR_SEED;
      end else if (!acc19_q && acc19) begin
        lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[LFSR_TAP_HI] ^ lfsr_q[LFSR_TAP_LO]};
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      acc19_q <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      acc19_q <= acc19_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: rtl/sid_wave.sv
// Per-voice waveform generator: decodes saw/tri/pulse/noise from the accumulator, ANDs the
// selected ones and registers the sample one clk_en tick after acc; all state holds without clk_en.
module sid_wave
  import sid_pkg::*;
(
  input  logic              clk,
  input  logic              n_reset,
  input  logic              clk_en,
  input  logic [ACC_W-1:0]  acc,
  input  logic              ring_in,
  input  logic [WAVE_W-1:0] pw,
  input  wave_ctrl_t        ctrl,
  output logic [WAVE_W-1:0] wave,
  output logic [7:0]        osc3,
  output logic [LFSR_W-1:0] lfsr
);

  logic [WAVE_W-1:0] saw_w, tri_w, pul_w, noi_w, mix;
  logic              tmsb;
  logic [WAVE_W-1:0] wave_q, wave_d;
  logic [7:0]        osc3_q, osc3_d;
  logic              unused_acc_lo;

  assign unused_acc_lo = ^acc[11:0];

  sid_noise_lfsr u_lfsr (
    .clk     (clk),
    .n_reset (n_reset),
    .clk_en  (clk_en),
    .acc19   (acc[19]),
    .test    (ctrl.test),
    .lfsr    (lfsr)
  );

  always_comb begin
    saw_w = acc[23:12];
    tmsb  = ctrl.ring_mod ? (acc[23] ^ ring_in) : acc[23];
    tri_w = {acc[22:12] ^ {11{tmsb}}, 1'b0};
    pul_w = (ctrl.test || (acc[23:12] >= pw)) ? 12'hFFF : 12'h000;
    // Noise reads the register before this tick's step lands.
    noi_w = noise_bits(lfsr);
  end

  always_comb begin
    mix = '1;
    if (ctrl.saw)      mix = mix & saw_w;
    if (ctrl.triangle) mix = mix & tri_w;
    if (ctrl.pulse)    mix = mix & pul_w;
    if (ctrl.noise)    mix = mix & noi_w;
    if (!(ctrl.saw || ctrl.triangle || ctrl.pulse || ctrl.noise)) mix = '0;
  end

  always_comb begin
    wave_d = wave_q;
    osc3_d = osc3_q;
    if (clk_en) begin
      wave_d = mix;
      osc3_d = mix[WAVE_W-1:4];
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wave_q <= '0;
      osc3_q <= '0;
    end else begin
      wave_q <= wave_d;
      osc3_q <= osc3_d;
    end
  end

  assign wave = wave_q;
  assign osc3 = osc3_q;

endmodule

// File: tb/tb_sid_wave.sv
// Randomized and directed checks of sid_wave against an arithmetic reference model.
module tb_sid_wave;

  logic        clk = 1'b0;
  logic        n_reset = 1'b0;
  logic        clk_en = 1'b0;
  logic [23:0] acc = '0;
  logic        ring_in = 1'b0;
  logic [11:0] pw = '0;
  logic [5:0]  ctrl = '0;   // {noise, pulse, saw, tri, ring_mod, test}
  logic [11:0] wave;
  logic [7:0]  osc3;
  logic [22:0] lfsr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int unsigned m_lfsr  = 32'h7FFFFF;
  int unsigned m_prev19 = 0;
  int unsigned m_wave  = 0;

  localparam int CNOI = 32, CPUL = 16, CSAW = 8, CTRI = 4, CRING = 2, CTEST = 1;

  sid_wave dut (
    .clk     (clk),
    .n_reset (n_reset),
    .clk_en  (clk_en),
    .acc     (acc),
    .ring_in (ring_in),
    .pw      (pw),
    .ctrl    (ctrl),
    .wave    (wave),
    .osc3    (osc3),
    .lfsr    (lfsr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model_mix(input int unsigned a, input int unsigned c,
                                             input int unsigned p, input int unsigned r,
                                             input int unsigned l);
    int unsigned top12, msb, t, res, noi, sel;
    int idx [8] = '{22, 20, 16, 13, 11, 7, 4, 2};
    top12 = a / 4096;
    msb   = a / 8388608;
    if ((c & CRING) != 0) msb = msb ^ r;
    t     = msb ? (~top12 & 32'h7FF) : (top12 & 32'h7FF);
    noi   = 0;
    for (int i = 0; i < 8; i++) noi += ((l >> idx[i]) & 1) << (11 - i);
    sel = 0;
    res = 32'hFFF;
    if ((c & CSAW) != 0) begin res &= top12; sel = 1; end
    if ((c & CTRI) != 0) begin res &= t * 2; sel = 1; end
    if ((c & CPUL) != 0) begin
      res &= (((c & CTEST) != 0) || top12 >= p) ? 32'hFFF : 0;
      sel = 1;
    end
    if ((c & CNOI) != 0) begin res &= noi; sel = 1; end
    return sel ? res : 0;
  endfunction

  // One clock: the model consumes the current inputs, then outputs are compared after the edge.
  task automatic step(input logic en, input string tag);
    int unsigned nw, nl, n19;
    nw = m_wave; nl = m_lfsr; n19 = m_prev19;
    clk_en = en;
    if (en) begin
      nw  = model_mix(acc, ctrl, pw, ring_in, m_lfsr);
      n19 = acc[19];
      if (ctrl[0]) nl = 32'h7FFFFF;
      else if (m_prev19 == 0 && acc[19]) nl = ((m_lfsr * 2) & 32'h7FFFFF) | (((m_lfsr >> 22) ^ (m_lfsr >> 17)) & 1);
    end
    @(posedge clk);
    #1;
    m_wave = nw; m_lfsr = nl; m_prev19 = n19;
    check({tag, ".wave"}, wave, m_wave);
    check({tag, ".osc3"}, osc3, m_wave >> 4);
    check({tag, ".lfsr"}, lfsr, m_lfsr);
  endtask

  task automatic drive(input logic [5:0] c, input logic [23:0] a, input logic [11:0] p, input logic r);
    ctrl = c; acc = a; pw = p; ring_in = r;
  endtask

  task automatic async_reset(input string tag);
    @(posedge clk); #3;
    n_reset = 1'b0;
    #1;
    m_wave = 0; m_lfsr = 32'h7FFFFF; m_prev19 = 0;
    check({tag, ".wave"}, wave, 0);
    check({tag, ".osc3"}, osc3, 0);
    check({tag, ".lfsr"}, lfsr, 32'h7FFFFF);
    #2;
    n_reset = 1'b1;
  endtask

  initial begin
    #12;
    check("rst.wave", wave, 0);
    check("rst.osc3", osc3, 0);
    check("rst.lfsr", lfsr, 32'h7FFFFF);
    n_reset = 1'b1;

    // Saw, then hold with clk_en low
    drive(6'(CSAW), 24'hABC123, 12'h0, 1'b0);
    step(1'b1, "saw");
    check("saw.const", wave, 12'hABC);
    check("saw.osc3c", osc3, 8'hAB);
    drive(6'(CSAW), 24'h123456, 12'h0, 1'b0);
    step(1'b0, "hold");
    check("hold.const", wave, 12'hABC);

    // Triangle, plain and ring-modulated
    drive(6'(CTRI), 24'h812345, 12'h0, 1'b0);
    step(1'b1, "tri");
    check("tri.const", wave, 12'hFDA);
    drive(6'(CTRI | CRING), 24'h812345, 12'h0, 1'b1);
    step(1'b1, "ring");
    check("ring.const", wave, 12'h024);

    // Pulse threshold, pw=0, test forcing
    drive(6'(CPUL), 24'h7FF000, 12'h800, 1'b0);
    step(1'b1, "pul.lo");
    check("pul.lo.const", wave, 12'h000);
    drive(6'(CPUL), 24'h800000, 12'h800, 1'b0);
    step(1'b1, "pul.hi");
    check("pul.hi.const", wave, 12'hFFF);
    drive(6'(CPUL), 24'h000000, 12'h000, 1'b0);
    step(1'b1, "pul.pw0");
    drive(6'(CPUL | CTEST), 24'h000000, 12'h800, 1'b0);
    step(1'b1, "pul.test");
    check("pul.test.const", wave, 12'hFFF);

    // Noise stepping
    drive(6'(CNOI), 24'h07FFFF, 12'h0, 1'b0);
    step(1'b1, "noi.a");
    drive(6'(CNOI), 24'h080000, 12'h0, 1'b0);
    step(1'b1, "noi.edge");
    check("noi.edge.const", lfsr, 23'h7FFFFE);
    drive(6'(CNOI), 24'h0FFFFF, 12'h0, 1'b0);
    step(1'b1, "noi.held");
    check("noi.held.const", lfsr, 23'h7FFFFE);
    drive(6'(CNOI), 24'h000000, 12'h0, 1'b0);
    step(1'b1, "noi.low");
    drive(6'(CNOI | CTEST), 24'h080000, 12'h0, 1'b0);
    step(1'b1, "noi.test");
    check("noi.test.const", lfsr, 23'h7FFFFF);
    drive(6'(CNOI), 24'h000000, 12'h0, 1'b0);
    step(1'b1, "noi.rel");
    drive(6'(CNOI), 24'h080000, 12'h0, 1'b0);
    step(1'b1, "noi.rel.edge");
    check("noi.rel.const", lfsr, 23'h7FFFFE);

    // Combinations
    drive(6'(CSAW | CPUL), 24'hF00000, 12'h100, 1'b0);
    step(1'b1, "sawpul");
    check("sawpul.const", wave, 12'hF00);
    drive(6'(CSAW | CTRI), 24'h400000, 12'h100, 1'b0);
    step(1'b1, "sawtri");
    check("sawtri.const", wave, 12'h000);
    drive(6'(CRING), 24'hFFFFFF, 12'h000, 1'b1);
    step(1'b1, "none");
    check("none.const", wave, 12'h000);

    async_reset("rst.mid");

    // Randomized run with sporadic clk_en gaps, test pulses and resets
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] c;
      c = 6'($urandom);
      c[0] = ($urandom_range(0, 15) == 0);
      acc = acc + 24'($urandom_range(0, 32'h30000));
      ctrl = c;
      pw = 12'($urandom);
      ring_in = 1'($urandom);
      step($urandom_range(0, 7) != 0, "rand");
      if (i % 750 == 749) async_reset("rand.rst");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
